// File: rtl/s_inv_convertion_seq_if.sv
// ============================================================================
// Module   : s_inv_convertion_seq_if
// Brief    : Input/output valid-ready stream bundle for the inverse
//            Kuznyechik S-layer (128-bit blocks on both sides).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface s_inv_convertion_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    // Upstream/downstream side: supplies blocks and consumes results
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // Substitution block side
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

`default_nettype wire

// File: rtl/s_inv_convertion_seq.sv
// ============================================================================
// Module   : s_inv_convertion_seq
// Brief    : Inverse Kuznyechik nonlinear layer (S^-1). Substitutes
//            BYTES_PER_CYCLE bytes of a 128-bit block per clock through
//            inverse-pi ROMs; valid/ready handshake on both sides.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module s_inv_convertion_seq #(
    parameter int BYTES_PER_CYCLE = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    s_inv_convertion_seq_if.slave       bus,
    input  logic                        abort,
    output logic                        busy
);

    localparam int N       = 16 / BYTES_PER_CYCLE;
    localparam int c_CNT_W = (N > 1) ? $clog2(N) : 1;

    // Forward pi table, pi[0] in the most significant byte.
    localparam logic [2047:0] c_PI = {
        128'hFCEEDD11CF6E3116FBC4FADA23C5044D,
        128'hE977F0DB932E99BA1736F1BB14CD5FC1,
        128'hF918655AE25CEF21811C3C428B018E4F,
        128'h058402AEE36A8FA0060BED987FD4D31F,
        128'hEB342C51EAC848ABF22A68A2FD3ACECC,
        128'hB5700E56080C7612BF7213479CB75D87,
        128'h15A19629107B9AC7F391786F9D9EB2B1,
        128'h3275193DFF358A7E6D54C680C3BD0D57,
        128'hDFF524A93EA843C9D779D6F67C22B903,
        128'hE00FECDE7A94B0BCDCE828504E330A4A,
        128'hA79760731E0062441AB83882649F2641,
        128'hAD454692275E552F8CA3A57D69D5953B,
        128'h0758B34086AC1DF730376BE488D9E789,
        128'hE11B83494C3FF8FE8D53AA90CAD88561,
        128'h207167A42D2B095BCB9B25D0BEE56C52,
        128'h59A674D2E6F4B4C0D166AFC2394B63B6
    };

    // Builds the inverse table at elaboration so it is exactly pi^-1 by
    // construction; result is stored with piinv[v] at bits [8v+7:8v].
    function automatic logic [2047:0] f_invert_pi(input logic [2047:0] pi);
        logic [2047:0] inv;
        logic [7:0]    y;
        inv = '0;
        for (int x = 0; x < 256; x++) begin
            y = pi[(255 - x) * 8 +: 8];
            inv[{y, 3'b000} +: 8] = 8'(x);
        end
        return inv;
    endfunction

    localparam logic [2047:0] c_PIINV = f_invert_pi(c_PI);

    generate
        if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
              BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bytes_per_cycle
            $error("s_inv_convertion_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic [127:0]         r_work;
    logic [127:0]         w_work_next;
    logic [3:0]           w_lane_base;
    logic [7:0]           w_lane_in  [BYTES_PER_CYCLE];
    logic [7:0]           w_lane_out [BYTES_PER_CYCLE];

    // First byte index handled in the current BUSY cycle
    assign w_lane_base = 4'(int'(r_cnt) * BYTES_PER_CYCLE);

    generate
        for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
            assign w_lane_in[j]  = r_work[{4'(w_lane_base + 4'(j)), 3'b000} +: 8];
            assign w_lane_out[j] = c_PIINV[{w_lane_in[j], 3'b000} +: 8];
        end
    endgenerate

    // State, byte counter and work block registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_work  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_work  <= w_work_next;
        end
    end

    // Next-state logic: abort wins over accept, substitution and hand-off
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_work_next  = r_work;
        if (abort) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        w_work_next  = bus.in_data;
                        w_cnt_next   = '0;
                        w_state_next = BUSY;
                    end
                end
                BUSY: begin
                    for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
                        w_work_next[{4'(w_lane_base + 4'(j)), 3'b000} +: 8] = w_lane_out[j];
                    end
                    if (int'(r_cnt) == N - 1) begin
                        w_cnt_next   = '0;
                        w_state_next = DONE;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        w_state_next = IDLE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // Handshake flags decode from state alone; data is always the register
    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.out_data  = r_work;
    assign busy          = (r_state == BUSY);

endmodule

`default_nettype wire

// File: doc/s_inv_convertion_seq.md
Name: s_inv_convertion_seq

Overview:
- Inverse Kuznyechik nonlinear layer (S^-1) for the decoder datapath.
- Applies the inverse pi permutation to each byte of a 128-bit block.
- Processes BYTES_PER_CYCLE lanes per clock, which trades area against latency.
- Sits between the inverse L stage and the round-key XOR; uses a valid/ready handshake on both sides.

Parameters:
- BYTES_PER_CYCLE, 1, bytes substituted per clock; legal values 1, 2, 4, 8, 16. Any other value is an elaboration error.
- N (localparam), 16/BYTES_PER_CYCLE, number of substitution cycles per block.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset, released synchronously upstream.
- in_valid  input  1  in_data holds a block to decode.
- in_ready  output  1  block can accept in_data this cycle.
- in_data  input  128  input block; byte i = bits [8i+7:8i].
- out_valid  output  1  out_data holds a finished block.
- out_ready  input  1  downstream consumes out_data.
- out_data  output  128  S^-1(in_data), byte-wise, same byte mapping as in_data.
- abort  input  1  synchronous flush to IDLE.
- busy  output  1  high in the BUSY state.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, cnt=0, work register=0.
  - in_ready=1, out_valid=0, busy=0, out_data=0.
- Inverse table:
  - 256x8 combinational ROM per lane, BYTES_PER_CYCLE instances.
  - Contents: the exact inverse of the forward pi table, i.e. piinv[pi[x]]=x for all x.
  - Spot values: piinv[FC]=00, piinv[EE]=01, piinv[00]=A5, piinv[B6]=FF, piinv[01]=2D.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid && in_ready: work<=in_data, cnt<=0, go to BUSY.
- BUSY:
  - in_ready=0, busy=1.
  - Each cycle, lanes j = cnt*BYTES_PER_CYCLE .. cnt*BYTES_PER_CYCLE+BYTES_PER_CYCLE-1 are replaced by piinv of their current value. Other bytes hold.
  - cnt increments by 1.
  - When cnt==N-1, the final lanes are written, cnt<=0, go to DONE.
- DONE:
  - out_valid=1; out_data=work, held stable until the transfer.
  - On out_ready, go to IDLE; out_valid deasserts on the next cycle.
- Latency:
  - Accept at edge k; out_valid is high after edge k+N (16 cycles for the default).
  - Throughput: one block per N+2 cycles, since IDLE and DONE each cost one cycle with out_ready tied high.
- in_ready is combinational from state only; it never depends on in_valid.
- out_data stays registered (work) at all times. It is only meaningful while out_valid=1.
- Boundary rules:
  - in_valid in BUSY/DONE is ignored; no accept, and in_data is not sampled.
  - out_ready while out_valid=0 has no effect.
  - out_ready held low in DONE: stall indefinitely, data stable, no new accept.
  - abort=1 in any state: next state IDLE, cnt=0, out_valid=0. work is not cleared. abort has priority over accept and completion in the same cycle.
  - In BUSY with BYTES_PER_CYCLE=16, N=1: one BUSY cycle, then DONE.
  - Reset asserted mid-BUSY or mid-DONE: immediate return to reset values; the partial block is lost.
- Each byte is substituted exactly once per block; no double application across cnt wrap.

Test Plan:
- Known vector: in_data=b66cd8887d38e8d77765aeea0c9a7efc with out_ready=1 -> out_data=ffeeddccbbaa99881122334455667700. out_valid rises exactly 16 cycles after the accept edge (BYTES_PER_CYCLE=1).
- Second vector, rerun for BYTES_PER_CYCLE=1,4,16: in=559d8dd7bd06cbfe7e7b262523280d39 -> out=b66cd8887d38e8d77765aeea0c9a7efc. Latency is 16, 4 and 1 cycles respectively.
- Table sweep: 16 blocks covering all 256 byte values; every out byte equals piinv(in byte). Spot checks: FC->00, 00->A5, B6->FF.
- Backpressure: out_ready=0 for 20 cycles in DONE, with in_valid=1 and new in_data toggling. out_data stays stable and in_ready=0. After out_ready=1, the new block is accepted 1 cycle later.
- Abort at cnt=7 -> IDLE on the next cycle, out_valid never asserts. The following block decodes correctly with full latency.
- Reset pulse (rst_n=0) mid-BUSY -> outputs go to reset values asynchronously, in_ready=1 after release. A subsequent known vector decodes correctly.
